// File: rtl/mcmult_pkg.sv
// Shared types, default sizes and helpers for the digit-serial multiplier.
// Optional multiply-accumulate mode is enabled with `define MCMULT_ACC_EN.
package mcmult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DEF_DW   = 4;
  localparam int DEF_MAXD = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Extension bit for a DW-bit digit: only the top used digit of a signed
  // operand carries the sign; every other digit is an unsigned magnitude.
  function automatic logic ext_bit(input logic sign, input logic is_top, input logic msb);
    return sign & is_top & msb;
  endfunction

endpackage

// File: rtl/mcmult_digit_mul.sv
// Combinational (DW+1)x(DW+1) signed digit multiplier.
module mcmult_digit_mul #(
  parameter int DW = 4
) (
  input  logic signed [DW:0]     x,
  input  logic signed [DW:0]     y,
  output logic signed [2*DW+1:0] p
);

  assign p = x * y;

endmodule

// File: rtl/mcmult_param.sv
// Parametrised digit-serial multiplier: one digit product accumulated per cycle.
// Define MCMULT_ACC_EN to add the 'acc' request input (multiply-accumulate).
module mcmult_param
  import mcmult_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int MAXD = DEF_MAXD,
  parameter int LENW = (clog2(MAXD) < 1) ? 1 : clog2(MAXD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*MAXD-1:0]   a,
  input  logic [DW*MAXD-1:0]   b,
  input  logic [LENW-1:0]      a_len,
  input  logic [LENW-1:0]      b_len,
  input  logic                 sign,
`ifdef MCMULT_ACC_EN
  input  logic                 acc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*DW*MAXD-1:0] out
);

  localparam int W  = DW * MAXD;
  localparam int PW = 2 * DW + 2;
  localparam int EW = (PW > 2 * W) ? PW : 2 * W;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [LENW-1:0]   la_q, la_d, lb_q, lb_d;
  logic [LENW-1:0]   i_q, i_d, j_q, j_d;
  logic              sign_q, sign_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DW:0]          x_dig, y_dig;
  logic signed [PW-1:0] pp;
  logic signed [EW-1:0] pp_ext;
  logic [EW-1:0]        pp_shl;
  int                   shamt;

  always_comb begin
    x_dig[DW-1:0] = a_q[DW*int'(j_q) +: DW];
    y_dig[DW-1:0] = b_q[DW*int'(i_q) +: DW];
    x_dig[DW]     = ext_bit(sign_q, j_q == la_q, x_dig[DW-1]);
    y_dig[DW]     = ext_bit(sign_q, i_q == lb_q, y_dig[DW-1]);
    shamt         = DW * (int'(i_q) + int'(j_q));
    pp_ext        = EW'(pp);
    pp_shl        = pp_ext <<< shamt;
  end

  mcmult_digit_mul #(.DW(DW)) u_digit_mul (
    .x (x_dig),
    .y (y_dig),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    la_d    = la_q;
    lb_d    = lb_q;
    i_d     = i_q;
    j_d     = j_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          la_d    = (int'(a_len) > MAXD - 1) ? LENW'(MAXD - 1) : a_len;
          lb_d    = (int'(b_len) > MAXD - 1) ? LENW'(MAXD - 1) : b_len;
          sign_d  = sign;
          i_d     = '0;
          j_d     = '0;
          state_d = BUSY;
`ifdef MCMULT_ACC_EN
          // The previous result survives into this product only when asked to.
          acc_d   = acc ? acc_q : '0;
`endif
        end
      end
      BUSY: begin
        acc_d = acc_q + pp_shl[2*W-1:0];
        if (j_q == la_q) begin
          j_d = '0;
          if (i_q == lb_q) state_d = DONE;
          else             i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifndef MCMULT_ACC_EN
          acc_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      la_q        <= '0;
      lb_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      la_q        <= la_d;
      lb_q        <= lb_d;
      i_q         <= i_d;
      j_q         <= j_d;
      sign_q      <= sign_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = acc_q;

endmodule

// File: tb/tb_mcmult_param.sv
// Directed bench for mcmult_param (DW=4, MAXD=2); MCMULT_ACC_EN adds the MAC sequence.
module tb_mcmult_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic [0:0]  a_len, b_len;
  logic        sign;
  logic        acc_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcmult_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_len     (a_len),
    .b_len     (b_len),
    .sign      (sign),
`ifdef MCMULT_ACC_EN
    .acc       (acc_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  typedef struct {
    logic [7:0]  va, vb;
    logic        vla, vlb, vs;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Drive a request while in_ready is high; scramble inputs after the accept edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vla,
                      input logic vlb, input logic vs);
    chk("accept_ready", 32'(in_ready), 32'd1);
    a = va; b = vb; a_len = vla; b_len = vlb; sign = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; sign = ~vs;
    chk("busy_not_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_res(input string name, input logic [15:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_out"}, 32'(out), 32'(exp));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 16'h00E1, 1};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 16'h4000, 4};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 16'hFFFF, 4};
    vecs[3] = '{8'h07, 8'h9C, 1'b0, 1'b1, 1'b1, 16'hFD44, 2};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 16'hFE01, 4};
    vecs[5] = '{8'h08, 8'h07, 1'b0, 1'b0, 1'b1, 16'hFFC8, 1};
    vecs[6] = '{8'hF3, 8'h5F, 1'b0, 1'b1, 1'b0, 16'h011D, 2};
    vecs[7] = '{8'h81, 8'h0E, 1'b1, 1'b0, 1'b1, 16'h00FE, 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_i = 1'b0;
    a = '0; b = '0; a_len = '0; b_len = '0; sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      send(vecs[k].va, vecs[k].vb, vecs[k].vla, vecs[k].vlb, vecs[k].vs);
      wait_res($sformatf("vec%0d", k), vecs[k].exp_out, vecs[k].exp_lat);
      consume();
    end

    // Backpressure: result held while a new request waits at the input.
    send(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    wait_res("bp", 16'h03A8, 4);
    a = 8'h02; b = 8'h03; a_len = 1'b0; b_len = 1'b0; sign = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_out%0d", k), 32'(out), 32'h03A8);
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
    chk("bp_after_hs_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_res("bp_next", 16'h0006, 1);
    consume();

    // Reset in the second BUSY cycle of an 8x8 multiply.
    send(8'h55, 8'h77, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_out", 32'(out), 32'd0);
    chk("rst_busy_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h03, 8'h05, 1'b1, 1'b1, 1'b0);
    wait_res("after_rst", 16'h000F, 4);
    consume();

`ifdef MCMULT_ACC_EN
    acc_i = 1'b0;
    send(8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    wait_res("mac0", 16'h0006, 1);
    consume();
    acc_i = 1'b1;
    send(8'h04, 8'h05, 1'b0, 1'b0, 1'b0);
    wait_res("mac1", 16'h001A, 1);
    consume();
    acc_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
